// File: rtl/adder_result_fifo_if.sv
// Valid/ready result channel carried between the adder stage, the result FIFO and the consumer.
// master drives data/valid, slave returns ready.
interface adder_result_fifo_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/adder_result_fifo.sv
// DEPTH-entry result FIFO between the adder stage and its consumer, with fill level output.
// Optional push statistics (stat_count/stat_sum) are built when ADDER_RESULT_FIFO_STATS_EN is defined.
module adder_result_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    adder_result_fifo_if.slave  in_if,
    adder_result_fifo_if.master out_if,
    output logic [LVL_W-1:0]    level
`ifdef ADDER_RESULT_FIFO_STATS_EN
    ,
    output logic [15:0]         stat_count,
    output logic [WIDTH+15:0]   stat_sum
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // DEPTH need not be a power of two, so pointers wrap explicitly at DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake qualification decoded from the registered level only.
    always_comb begin
        w_full  = (r_level == LVL_W'(DEPTH));
        w_empty = (r_level == {LVL_W{1'b0}});
        w_push  = in_if.valid && !w_full;
        w_pop   = out_if.ready && !w_empty;
    end

    assign in_if.ready  = !w_full;
    assign out_if.valid = !w_empty;
    assign level        = r_level;

    // Head-of-queue presentation; forced to zero when nothing is stored.
    always_comb begin
        if (w_empty) begin
            out_if.data = {WIDTH{1'b0}};
        end else begin
            out_if.data = r_mem[r_rd_ptr];
        end
    end

    // Storage write; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= in_if.data;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef ADDER_RESULT_FIFO_STATS_EN
    logic [15:0]       r_stat_count;
    logic [WIDTH+15:0] r_stat_sum;

    // Push statistics: saturating count, wrapping sum of zero-extended results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_count <= 16'h0000;
            r_stat_sum   <= {(WIDTH + 16){1'b0}};
        end else if (w_push) begin
            if (r_stat_count != 16'hFFFF) begin
                r_stat_count <= r_stat_count + 16'd1;
            end
            r_stat_sum <= r_stat_sum + {16'h0000, in_if.data};
        end
    end

    assign stat_count = r_stat_count;
    assign stat_sum   = r_stat_sum;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Scoreboard bench for adder_result_fifo: queue-based reference model, negedge monitor.
module tb_adder_result_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [LVL_W-1:0] level;
`ifdef ADDER_RESULT_FIFO_STATS_EN
    logic [15:0]       stat_count;
    logic [WIDTH+15:0] stat_sum;
`endif

    adder_result_fifo_if #(.WIDTH(WIDTH)) in_if ();
    adder_result_fifo_if #(.WIDTH(WIDTH)) out_if ();

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_if  (in_if),
        .out_if (out_if),
        .level  (level)
`ifdef ADDER_RESULT_FIFO_STATS_EN
        ,
        .stat_count (stat_count),
        .stat_sum   (stat_sum)
`endif
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    bit               mon_en = 1'b0;
    int               m_lvl = 0;
    bit               m_pushed = 1'b0;
    int unsigned      m_cnt = 0;
    longint unsigned  m_sum = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue length; acceptance follows from it.
    always @(posedge clk) begin : model
        bit push;
        bit pop;
        m_pushed = 1'b0;
        if (!rst) begin
            m_lvl = 0;
            exp_q.delete();
            m_cnt = 0;
            m_sum = 0;
        end else begin
            push = in_if.valid && (m_lvl < DEPTH);
            pop  = out_if.ready && (m_lvl > 0);
            if (push) begin
                exp_q.push_back(in_if.data);
                m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                m_sum = (m_sum + longint'(in_if.data)) % (64'd1 << (WIDTH + 16));
            end
            m_lvl = m_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
            m_pushed = push;
        end
    end

    // Monitor: flags, level and head data compared every cycle away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", 64'(level), 64'(m_lvl));
            chk("in_ready", 64'(in_if.ready), 64'(m_lvl != DEPTH));
            chk("out_valid", 64'(out_if.valid), 64'(m_lvl != 0));
            if (out_if.valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got %0h expected no output at %0t", out_if.data, $time);
                end else begin
                    chk("out_data", 64'(out_if.data), 64'(exp_q[0]));
                    if (out_if.ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("out_data_empty", 64'(out_if.data), 64'd0);
            end
`ifdef ADDER_RESULT_FIFO_STATS_EN
            chk("stat_count", 64'(stat_count), 64'(m_cnt));
            chk("stat_sum", 64'(stat_sum), m_sum);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int idx;
        int cyc;
        bit tog;
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b1;
        step();

        // single push, hold under back-pressure, then pop
        drive(1'b1, 16'h0005, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        repeat (3) step();
        drive(1'b0, 16'h0000, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        step();

        // fill, rejected fifth push, drain
        fill4();
        drive(1'b1, 16'h0005, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b1);
        repeat (5) step();

        // full with simultaneous pop: 9 enters on the second edge
        drive(1'b0, 16'h0000, 1'b0);
        fill4();
        drive(1'b1, 16'h0009, 1'b1);
        step();
        step();
        drive(1'b0, 16'h0000, 1'b1);
        repeat (4) step();

        // wrap stress with toggling consumer
        idx = 0;
        cyc = 0;
        tog = 1'b1;
        while (idx < 20 && cyc < 200) begin
            drive(1'b1, WIDTH'(16'h0010 + idx), tog);
            step();
            if (m_pushed) idx++;
            tog = !tog;
            cyc++;
        end
        if (idx < 20) begin
            checks++;
            errors++;
            $display("FAIL wrap_budget: got %0d pushes expected 20", idx);
        end
        drive(1'b0, 16'h0000, 1'b1);
        repeat (6) step();
        chk("wrap_drained_q", 64'(exp_q.size()), 64'd0);

        // randomized traffic
        repeat (400) begin
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            step();
        end

        // reset mid-stream, then a fresh push
        fill4();
        rst = 1'b0;
        drive(1'b1, 16'hAAAA, 1'b1);
        step();
        rst = 1'b1;
        drive(1'b1, 16'h1234, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b1);
        repeat (2) step();

`ifdef ADDER_RESULT_FIFO_STATS_EN
        do_reset();
        repeat (3) begin
            drive(1'b1, 16'hFFFF, 1'b0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        chk("stats_count3", 64'(stat_count), 64'd3);
        chk("stats_sum3", 64'(stat_sum), 64'h2FFFD);
        do_reset();
        step();
        chk("stats_count_rst", 64'(stat_count), 64'd0);
        chk("stats_sum_rst", 64'(stat_sum), 64'd0);
`else
        do_reset();
        step();
`endif
        drive(1'b0, 16'h0000, 1'b1);
        repeat (6) step();
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Downstream stage of the adder wrapper: accepts adder results over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the buffered results in order to the consumer (scoreboard/monitor) over a second valid/ready handshake.
- Decouples adder throughput from consumer back-pressure.
- Reports the fill level and, optionally, running statistics.

Parameters:
WIDTH, 16, data width of an adder result
DEPTH, 4, number of FIFO entries (>=2, need not be a power of two)
LVL_W, $clog2(DEPTH+1), width of the level output (derived, not overridden)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low (asserted when 0)
in_data  in  WIDTH  result from adder stage
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept (not full)
out_data  out  WIDTH  head-of-FIFO result
out_valid  out  1  out_data valid (not empty)
out_ready  in  1  consumer accepts out_data
level  out  LVL_W  number of stored entries, 0..DEPTH
stat_count  out  16  accepted results, present only with STATS_EN
stat_sum  out  WIDTH+16  running sum of accepted results, present only with STATS_EN

Behaviour:
- Sampling: all state updates on posedge clk; rst sampled only at the edge.
- Reset (rst==0 at edge), overriding any handshake in that cycle:
  - wr_ptr=0, rd_ptr=0, level=0.
  - out_valid=0, in_ready=1, out_data=0.
  - stat_count=0, stat_sum=0.
  - Storage array is not cleared.
- Push: in_valid && in_ready at an edge → mem[wr_ptr]<=in_data; wr_ptr advances.
- Pop: out_valid && out_ready at an edge → rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags, combinational from registered level:
  - in_ready = (level != DEPTH).
  - out_valid = (level != 0).
- out_data:
  - = mem[rd_ptr] when out_valid=1.
  - = 0 when empty.
  - Stable while out_valid && !out_ready.
- Latency: push at edge N → out_valid=1 and out_data valid after edge N; no combinational in→out path.
- Occupancy states, decoded from level:
  - EMPTY (level==0): push → PARTIAL, or FULL if DEPTH==1 (not allowed).
  - PARTIAL: push only → level+1, FULL when level reaches DEPTH; pop only → level-1, EMPTY at 0; push+pop → unchanged.
  - FULL (level==DEPTH): in_ready=0, no push; pop → PARTIAL.
- Boundary rules:
  - EMPTY with in_valid && out_ready: push only, no pop, no bypass.
  - FULL with in_valid && out_ready: pop only; the new push is accepted on the following edge (in_ready=1 then).
  - PARTIAL with simultaneous push/pop: both occur, level unchanged; works across pointer wrap.
- in_valid/in_data while in_ready=0: ignored, with no state change.
- Reset mid-stream: all entries are discarded; out_valid=0 after the reset edge; the first push after reset goes to entry 0.

Optional Feature:
- Macro: ADDER_RESULT_FIFO_STATS_EN.
- Defined:
  - stat_count increments on each push and saturates at 16'hFFFF.
  - stat_sum += zero-extended in_data on each push, wrapping modulo 2^(WIDTH+16).
  - Both update on the push edge; both are cleared by reset.
- Undefined: stat_count/stat_sum ports and their logic are absent; FIFO behaviour is identical.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1 → level=0, out_valid=0, in_ready=1, out_data=0.
- Single push: in_data=16'h0005, in_valid=1 for 1 cycle, out_ready=0 → after the edge, out_valid=1, out_data=5, level=1; held for 3 cycles; out_ready=1 → pop, level=0.
- Fill + back-pressure: push 1,2,3,4 with out_ready=0 → level=4, in_ready=0; push 5 attempted → ignored; then drain → outputs 1,2,3,4 in order, level 0.
- Full with simultaneous pop: full with 1..4, in_valid=1 with data 9, out_ready=1 → edge 1 pops 1 (level 3); edge 2 pushes 9 and pops 2; the drained sequence continues 3,4,9.
- Wrap stress: 20 results 0x0010..0x0023, in_valid=1 continuously, out_ready toggling 1,0,1,0 → output sequence identical to input, no loss or duplication, level never exceeds 4.
- With STATS_EN: push 16'hFFFF three times, then reset → stat_count=3, stat_sum=0x2FFFD; after reset both are 0.
